// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_2p dual-port RAM family.
// Holds the controller state encoding, read-during-write selectors and byte-lane merging.
package ram_pkg;

    typedef enum logic {
        RAM_CLEAR,
        RAM_READY
    } ram_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word and lane count be_merge can handle; callers zero-extend into these.
    localparam int MAX_WORD_W = 1024;
    localparam int MAX_BE_W   = 128;

    function automatic logic [MAX_WORD_W-1:0] be_merge(
        input logic [MAX_WORD_W-1:0] old_word,
        input logic [MAX_WORD_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be,
        input int                    byte_w
    );
        logic [MAX_WORD_W-1:0] lane_mask;
        logic [MAX_WORD_W-1:0] mask;
        logic [MAX_BE_W-1:0]   be_s;
        lane_mask = (MAX_WORD_W'(1) << byte_w) - MAX_WORD_W'(1);
        mask      = '0;
        be_s      = be;
        for (int b = 0; b < MAX_BE_W; b++) begin
            if (be_s[0]) begin
                mask = mask | (lane_mask << (b * byte_w));
            end
            be_s = be_s >> 1;
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return delay line: RD_LATENCY stages of valid/data, last stage drives the ack.
// Each data stage only loads alongside a valid, so the output word holds between acks.
module ram_rd_pipe #(
    parameter int WORD_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  vld_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic                  ack_o,
    output logic [WORD_WIDTH-1:0] data_o
);

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [WORD_WIDTH-1:0] data_q [RD_LATENCY];
    logic [WORD_WIDTH-1:0] data_d [RD_LATENCY];

    logic [RD_LATENCY-1:0] vld_src;
    logic [WORD_WIDTH-1:0] data_src [RD_LATENCY];

    always_comb begin
        vld_src     = '0;
        vld_src[0]  = vld_i;
        data_src[0] = data_i;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_src[i]  = vld_q[i-1];
            data_src[i] = data_q[i-1];
        end
    end

    always_comb begin
        vld_d = vld_src;
        for (int i = 0; i < RD_LATENCY; i++) begin
            data_d[i] = vld_src[i] ? data_src[i] : data_q[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign ack_o  = vld_q[RD_LATENCY-1];
    assign data_o = data_q[RD_LATENCY-1];

endmodule

// File: rtl/ram_2p.sv
// Simple dual-port RAM: byte-enabled write port, pipelined read port, selectable
// read-during-write result and an optional post-reset zeroing sweep.
module ram_2p
    import ram_pkg::*;
#(
    parameter int WORD_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int INDEX_WIDTH    = 4,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk_i,
    input  logic                             arstn_i,
    input  logic                             wr_i,
    input  logic [WORD_WIDTH/BYTE_WIDTH-1:0] wr_be_i,
    input  logic [INDEX_WIDTH-1:0]           wr_index_i,
    input  logic [WORD_WIDTH-1:0]            wr_data_i,
    output logic                             ack_wr_o,
    input  logic                             rd_i,
    input  logic [INDEX_WIDTH-1:0]           rd_index_i,
    output logic                             ack_rd_o,
    output logic [WORD_WIDTH-1:0]            rd_data_o,
    output logic                             busy_o
);

    localparam int         DEPTH     = 2 ** INDEX_WIDTH;
    localparam ram_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_READY;

    logic [WORD_WIDTH-1:0]  mem_q [DEPTH];
    ram_state_e             state_q, state_d;
    logic [INDEX_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                   ack_wr_q, ack_wr_d;

    logic                   mem_we_d;
    logic [INDEX_WIDTH-1:0] mem_addr_d;
    logic [WORD_WIDTH-1:0]  mem_data_d;
    logic                   rd_fire_d;
    logic [WORD_WIDTH-1:0]  wr_merged;
    logic [WORD_WIDTH-1:0]  rd_word;

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
            ack_wr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ack_wr_q  <= ack_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            RAM_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d = RAM_READY;
                end
            end
            default: state_d = RAM_READY;
        endcase
    end

    assign wr_merged = WORD_WIDTH'(be_merge(MAX_WORD_W'(mem_q[wr_index_i]),
                                            MAX_WORD_W'(wr_data_i),
                                            MAX_BE_W'(wr_be_i),
                                            BYTE_WIDTH));

    // Clear sweep owns the write port; user requests are dropped rather than queued.
    always_comb begin
        busy_o     = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = wr_index_i;
        mem_data_d = wr_merged;
        ack_wr_d   = 1'b0;
        rd_fire_d  = 1'b0;
        case (state_q)
            RAM_CLEAR: begin
                busy_o     = 1'b1;
                mem_we_d   = arstn_i;
                mem_addr_d = clr_cnt_q;
                mem_data_d = '0;
            end
            default: begin
                mem_we_d  = wr_i & arstn_i;
                ack_wr_d  = wr_i;
                rd_fire_d = rd_i & arstn_i;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (mem_we_d) begin
            mem_q[mem_addr_d] <= mem_data_d;
        end
    end

    // The array read is asynchronous here; same-index writes land at the edge, so this is old data.
    always_comb begin
        rd_word = mem_q[rd_index_i];
        if (RDW_MODE == RDW_NEW && wr_i && (wr_index_i == rd_index_i)) begin
            rd_word = wr_merged;
        end
    end

    ram_rd_pipe #(
        .WORD_WIDTH (WORD_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .vld_i   (rd_fire_d),
        .data_i  (rd_word),
        .ack_o   (ack_rd_o),
        .data_o  (rd_data_o)
    );

    assign ack_wr_o = ack_wr_q;

endmodule

// File: tb/tb_ram_2p.sv
// Directed bench for ram_2p: one instance with 1-cycle reads and old-data RDW,
// one with 2-cycle reads and new-data RDW, both driven by the same stimulus.
module tb_ram_2p;

    logic        clk;
    logic        arstn;
    logic        wr;
    logic [3:0]  be;
    logic [3:0]  widx;
    logic [31:0] wdata;
    logic        rd;
    logic [3:0]  ridx;

    logic        ack_wr0, ack_rd0, busy0;
    logic [31:0] rd_data0;
    logic        ack_wr1, ack_rd1, busy1;
    logic [31:0] rd_data1;

    int checks = 0;
    int fails  = 0;

    logic [31:0] dv [4];

    ram_2p #(
        .WORD_WIDTH(32), .BYTE_WIDTH(8), .INDEX_WIDTH(4),
        .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk_i(clk), .arstn_i(arstn),
        .wr_i(wr), .wr_be_i(be), .wr_index_i(widx), .wr_data_i(wdata), .ack_wr_o(ack_wr0),
        .rd_i(rd), .rd_index_i(ridx), .ack_rd_o(ack_rd0), .rd_data_o(rd_data0),
        .busy_o(busy0)
    );

    ram_2p #(
        .WORD_WIDTH(32), .BYTE_WIDTH(8), .INDEX_WIDTH(4),
        .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk_i(clk), .arstn_i(arstn),
        .wr_i(wr), .wr_be_i(be), .wr_index_i(widx), .wr_data_i(wdata), .ack_wr_o(ack_wr1),
        .rd_i(rd), .rd_index_i(ridx), .ack_rd_o(ack_rd1), .rd_data_o(rd_data1),
        .busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr = 1'b0; be = 4'h0; widx = 4'h0; wdata = 32'h0; rd = 1'b0; ridx = 4'h0;
    endtask

    // Waits out the sweep at negedges while counting busy cycles and any stray acks.
    task automatic sweep(output int cnt, output bit stray);
        cnt   = 0;
        stray = 1'b0;
        for (int i = 0; i < 40 && busy0; i++) begin
            cnt++;
            if (ack_wr0 || ack_wr1 || ack_rd0 || ack_rd1) stray = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        int  cnt;
        bit  stray;
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  stray;
        idle();
        arstn = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ack_wr0", ack_wr0, 0);  chk("rst_ack_wr1", ack_wr1, 0);
        chk("rst_ack_rd0", ack_rd0, 0);  chk("rst_ack_rd1", ack_rd1, 0);
        chk("rst_data0", rd_data0, 0);   chk("rst_data1", rd_data1, 0);
        chk("rst_busy0", busy0, 1);      chk("rst_busy1", busy1, 1);

        // Requests held through the whole sweep must be ignored.
        wr = 1'b1; widx = 4'd1; wdata = 32'hFFFF_FFFF; be = 4'hF;
        rd = 1'b1; ridx = 4'd1;
        arstn = 1'b1;
        sweep(cnt, stray);
        chk("clear_busy_cycles", cnt, 16);
        chk("clear_no_acks", {31'b0, stray}, 0);
        chk("clear_busy1_done", busy1, 0);
        idle();

        for (int k = 0; k < 18; k++) begin
            chk("clr_rd_ack0", ack_rd0, (k >= 1 && k <= 16) ? 1 : 0);
            chk("clr_rd_ack1", ack_rd1, (k >= 2 && k <= 17) ? 1 : 0);
            chk("clr_rd_data0", rd_data0, 0);
            chk("clr_rd_data1", rd_data1, 0);
            rd   = (k < 16);
            ridx = 4'(k);
            @(negedge clk);
        end
        idle();

        wr = 1'b1; widx = 4'd3; wdata = 32'hAABB_CCDD; be = 4'hF;
        @(negedge clk);
        chk("be_ack_wr0_a", ack_wr0, 1); chk("be_ack_wr1_a", ack_wr1, 1);
        wdata = 32'h1122_3344; be = 4'b0101;
        @(negedge clk);
        chk("be_ack_wr0_b", ack_wr0, 1); chk("be_ack_wr1_b", ack_wr1, 1);
        widx = 4'd4; wdata = 32'hFFFF_FFFF; be = 4'h0;
        rd = 1'b1; ridx = 4'd3;
        @(negedge clk);
        chk("be0_ack_wr0", ack_wr0, 1);  chk("be0_ack_wr1", ack_wr1, 1);
        chk("be_rd_ack0", ack_rd0, 1);   chk("be_rd_data0", rd_data0, 32'hAA22_CC44);
        wr = 1'b0; ridx = 4'd4;
        @(negedge clk);
        chk("wr_pulse0", ack_wr0, 0);    chk("wr_pulse1", ack_wr1, 0);
        chk("be_rd_ack1", ack_rd1, 1);   chk("be_rd_data1", rd_data1, 32'hAA22_CC44);
        chk("be0_rd_data0", rd_data0, 0);
        rd = 1'b0;
        @(negedge clk);
        chk("be0_rd_ack1", ack_rd1, 1);  chk("be0_rd_data1", rd_data1, 0);
        chk("be0_rd_idle0", ack_rd0, 0);
        @(negedge clk);

        dv[0] = 32'h1000_0000; dv[1] = 32'h2000_0001;
        dv[2] = 32'h3000_0002; dv[3] = 32'h4000_0003;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) chk("pipe_wr_ack0", ack_wr0, 1);
            wr = 1'b1; be = 4'hF; widx = 4'(k); wdata = dv[k];
            @(negedge clk);
        end
        wr = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k == 0) chk("pipe_wr_last_ack1", ack_wr1, 1);
            chk("pipe_ack0", ack_rd0, (k >= 1 && k <= 4) ? 1 : 0);
            chk("pipe_data0", rd_data0, (k == 0) ? 32'h0 : dv[(k > 4) ? 3 : k - 1]);
            chk("pipe_ack1", ack_rd1, (k >= 2 && k <= 5) ? 1 : 0);
            chk("pipe_data1", rd_data1, (k < 2) ? 32'h0 : dv[(k > 5) ? 3 : k - 2]);
            rd   = (k < 4);
            ridx = 4'(k);
            @(negedge clk);
        end
        idle();

        wr = 1'b1; widx = 4'd5; wdata = 32'hDEAD_BEEF; be = 4'hF;
        rd = 1'b1; ridx = 4'd5;
        @(negedge clk);
        chk("rdw_ack0", ack_rd0, 1);     chk("rdw_old_data0", rd_data0, 32'h0);
        widx = 4'd6; wdata = 32'h1234_5678; be = 4'b0011; ridx = 4'd6;
        @(negedge clk);
        chk("rdw_ack1", ack_rd1, 1);     chk("rdw_new_data1", rd_data1, 32'hDEAD_BEEF);
        chk("rdw_old_part0", rd_data0, 32'h0);
        wr = 1'b0; ridx = 4'd5;
        @(negedge clk);
        chk("rdw_merge_data1", rd_data1, 32'h0000_5678);
        chk("rdw_after_data0", rd_data0, 32'hDEAD_BEEF);
        ridx = 4'd6;
        @(negedge clk);
        chk("rdw_after_data1", rd_data1, 32'hDEAD_BEEF);
        chk("rdw_after_part0", rd_data0, 32'h0000_5678);
        rd = 1'b0;
        @(negedge clk);
        chk("rdw_after_part1", rd_data1, 32'h0000_5678);
        chk("rdw_idle0", ack_rd0, 0);
        @(negedge clk);
        chk("rdw_idle1", ack_rd1, 0);

        rd = 1'b1; ridx = 4'd5;
        @(negedge clk);
        chk("mid_rst_ack0", ack_rd0, 1); chk("mid_rst_data0", rd_data0, 32'hDEAD_BEEF);
        rd = 1'b0; arstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_noack1", ack_rd1, 0);
        chk("mid_rst_data1", rd_data1, 0);
        chk("mid_rst_data0_cleared", rd_data0, 0);
        chk("mid_rst_busy0", busy0, 1);
        @(negedge clk);
        chk("mid_rst_noack1_b", ack_rd1, 0);
        arstn = 1'b1;
        sweep(cnt, stray);
        chk("reclear_busy_cycles", cnt, 16);
        chk("reclear_no_acks", {31'b0, stray}, 0);

        rd = 1'b1; ridx = 4'd5;
        @(negedge clk);
        rd = 1'b0;
        chk("reclear_ack0", ack_rd0, 1); chk("reclear_data0", rd_data0, 0);
        @(negedge clk);
        chk("reclear_ack1", ack_rd1, 1); chk("reclear_data1", rd_data1, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
